serv_rf_ram_sched: RTL

//  Schedules register-file reads and writes onto the single-port 2-bit RF macro (one shared addr, one we).

---
 rtl/serv_rf_ram_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/serv_rf_ram_sched.sv
// Schedules serv RF reads/writes onto a single-port RAM macro; writes are posted in a small FIFO.
// Optional build macro SERV_RF_WFWD_EN: forward queued write data to reads instead of stalling them.
module serv_rf_ram_sched #(
   parameter int width      = 2,
   parameter int csr_regs   = 4,
   parameter int depth      = 32*(32+csr_regs)/width,
   parameter int WBUF_DEPTH = 4,
   localparam int AW = $clog2(depth),
   localparam int CW = $clog2(WBUF_DEPTH)+1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wen,
   input  logic [AW-1:0]    i_waddr,
   input  logic [width-1:0] i_wdata,
   output logic             o_wready,
   input  logic             i_ren,
   input  logic [AW-1:0]    i_raddr,
   output logic             o_rready,
   output logic             o_rvalid,
   output logic [width-1:0] o_rdata,
   output logic [CW-1:0]    o_wbuf_cnt,
   output logic             o_mem_ce,
   output logic             o_mem_we,
   output logic [AW-1:0]    o_mem_addr,
   output logic [width-1:0] o_mem_wdata,
   output logic [width-1:0] o_mem_wmask,
   input  logic [width-1:0] i_mem_rdata
);

   localparam int PW = $clog2(WBUF_DEPTH);

   logic [AW-1:0]    wb_addr_q [WBUF_DEPTH];
   logic [AW-1:0]    wb_addr_d [WBUF_DEPTH];
   logic [width-1:0] wb_data_q [WBUF_DEPTH];
   logic [width-1:0] wb_data_d [WBUF_DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rvalid_q, rvalid_d;

   logic full, empty, hit, rd_block, rd_acc, wr_acc, push, pop;
   logic [PW-1:0] idx;

`ifdef SERV_RF_WFWD_EN
   logic             fwd_hit_q, fwd_hit_d;
   logic [width-1:0] fwd_data_q, fwd_data_d;
   logic [width-1:0] hit_data;
`endif

   assign full  = (cnt_q == CW'(WBUF_DEPTH));
   assign empty = (cnt_q == '0);

   // Walk live entries oldest to youngest so the last match is the youngest one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef SERV_RF_WFWD_EN
      hit_data = '0;
`endif
      for (int k = 0; k < WBUF_DEPTH; k++) begin
         idx = rd_ptr_q + PW'(k);
         if (CW'(k) < cnt_q && wb_addr_q[idx] == i_raddr) begin
            hit = 1'b1;
`ifdef SERV_RF_WFWD_EN
            hit_data = wb_data_q[idx];
`endif
         end
      end
   end

`ifdef SERV_RF_WFWD_EN
   assign rd_block = 1'b0;
`else
   assign rd_block = hit;
`endif

   assign o_wready    = !i_rst && !full;
   assign o_rready    = !i_rst && !full && !rd_block;
   assign rd_acc      = i_ren && o_rready;
   assign wr_acc      = i_wen && o_wready;
   assign o_mem_wmask = '1;

   // Port grant: read, then FIFO drain, then direct write into an empty FIFO.
   always_comb begin
      o_mem_ce    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = i_raddr;
      o_mem_wdata = i_wdata;
      push        = 1'b0;
      pop         = 1'b0;
      if (i_rst) begin
         o_mem_ce = 1'b0;
      end else if (rd_acc) begin
         o_mem_ce = 1'b1;
         push     = wr_acc;
      end else if (!empty) begin
         o_mem_ce    = 1'b1;
         o_mem_we    = 1'b1;
         o_mem_addr  = wb_addr_q[rd_ptr_q];
         o_mem_wdata = wb_data_q[rd_ptr_q];
         pop         = 1'b1;
         push        = wr_acc;
      end else if (wr_acc) begin
         o_mem_ce   = 1'b1;
         o_mem_we   = 1'b1;
         o_mem_addr = i_waddr;
      end
   end

   always_comb begin
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (push) begin
         wb_addr_d[wr_ptr_q] = i_waddr;
         wb_data_d[wr_ptr_q] = i_wdata;
      end
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      rvalid_d = rd_acc;
`ifdef SERV_RF_WFWD_EN
      fwd_hit_d  = rd_acc && hit;
      fwd_data_d = hit_data;
`endif
   end

   always_ff @(posedge i_clk) begin
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef SERV_RF_WFWD_EN
      fwd_data_q <= fwd_data_d;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
`ifdef SERV_RF_WFWD_EN
         fwd_hit_q <= 1'b0;
`endif
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
`ifdef SERV_RF_WFWD_EN
         fwd_hit_q <= fwd_hit_d;
`endif
      end
   end

   assign o_rvalid   = rvalid_q;
   assign o_wbuf_cnt = cnt_q;
`ifdef SERV_RF_WFWD_EN
   assign o_rdata = !rvalid_q ? '0 : (fwd_hit_q ? fwd_data_q : i_mem_rdata);
`else
   assign o_rdata = rvalid_q ? i_mem_rdata : '0;
`endif

endmodule
